// File: rtl/reg_write_arbiter_if.sv
// Bus between write clients and the register arbiter: requests in, register strobes and acks out.
interface reg_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int PTR_W = 2
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic                   clr_req;
  logic [N_REQ-1:0]       gnt;
  logic                   clr_ack;
  logic                   reg_load;
  logic                   reg_clear;
  logic [WIDTH-1:0]       reg_d;
  logic                   busy;
  logic [PTR_W-1:0]       last_id;

  modport master (
    output req, req_data, clr_req,
    input  gnt, clr_ack, reg_load, reg_clear, reg_d, busy, last_id
  );

  modport slave (
    input  req, req_data, clr_req,
    output gnt, clr_ack, reg_load, reg_clear, reg_d, busy, last_id
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a shared load/clear register; clear requests take priority.
//
// state | meaning
// IDLE  | arbitrate: clear first, else round-robin write winner
// CLEAR | reg_clear and clr_ack pulse
// LOAD  | reg_load pulses with latched winner data on reg_d
// ACK   | gnt[win_id] pulses, last_id takes win_id on exit
module reg_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  reg_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_LOAD  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] last_id_q;
  logic [PTR_W-1:0] win_id_q;
  logic [WIDTH-1:0] reg_d_q;
  logic [PTR_W-1:0] rr_idx;
  logic             rr_found;
  logic [WIDTH-1:0] sel_data;
  logic             take_write;
  logic [N_REQ-1:0] gnt_vec;
  int unsigned      idx;

  // Search starts one past the last granted client and wraps within N_REQ.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    idx      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_id_q) + k) % N_REQ;
      if (!rr_found && bus.req[idx]) begin
        rr_found = 1'b1;
        rr_idx   = PTR_W'(idx);
      end
    end
  end

  assign sel_data   = bus.req_data[rr_idx*WIDTH +: WIDTH];
  assign take_write = (state == S_IDLE) && !bus.clr_req && rr_found;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.clr_req)   state_nxt = S_CLEAR;
        else if (rr_found) state_nxt = S_LOAD;
      end
      S_CLEAR: state_nxt = S_IDLE;
      S_LOAD:  state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_vec = '0;
    if (state == S_ACK) gnt_vec[win_id_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      last_id_q <= PTR_W'(N_REQ - 1);
      win_id_q  <= '0;
      reg_d_q   <= '0;
    end else begin
      state <= state_nxt;
      if (take_write) begin
        win_id_q <= rr_idx;
        reg_d_q  <= sel_data;
      end
      if (state == S_ACK) last_id_q <= win_id_q;
    end
  end

  // Every output decodes from registered state only.
  assign bus.gnt       = gnt_vec;
  assign bus.reg_load  = (state == S_LOAD);
  assign bus.reg_clear = (state == S_CLEAR);
  assign bus.clr_ack   = (state == S_CLEAR);
  assign bus.busy      = (state != S_IDLE);
  assign bus.reg_d     = reg_d_q;
  assign bus.last_id   = last_id_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized clients
// checked every cycle against a transaction-schedule model of the arbiter.
module tb_reg_write_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.N_REQ(N), .WIDTH(W), .PTR_W(PW)) bus ();

  reg_write_arbiter #(.N_REQ(N), .WIDTH(W), .PTR_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted operation schedules its future per-cycle outputs in a queue.
  typedef struct {
    bit         busy;
    bit         load;
    bit         clear;
    logic [N-1:0] gnt;
    int         win;
  } rec_t;

  rec_t         sched[$];
  rec_t         cur;
  int           m_last = N - 1;
  logic [W-1:0] m_d = '0;
  bit           model_valid = 1'b0;

  function automatic rec_t mk(bit b, bit l, bit c, logic [N-1:0] g, int w);
    rec_t r;
    r.busy = b; r.load = l; r.clear = c; r.gnt = g; r.win = w;
    return r;
  endfunction

  initial cur = mk(0, 0, 0, '0, 0);

  always @(posedge clk) begin
    if (rst) begin
      sched.delete();
      cur         = mk(0, 0, 0, '0, 0);
      m_last      = N - 1;
      m_d         = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (cur.gnt != '0) m_last = cur.win;
      if (!cur.busy) begin
        if (bus.clr_req) begin
          sched.push_back(mk(1, 0, 1, '0, 0));
        end else begin
          int pick;
          pick = -1;
          for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (pick < 0 && bus.req[c]) pick = c;
          end
          if (pick >= 0) begin
            m_d = bus.req_data[pick*W +: W];
            sched.push_back(mk(1, 1, 0, '0, pick));
            sched.push_back(mk(1, 0, 0, N'(1) << pick, pick));
          end
        end
      end
      cur = (sched.size() > 0) ? sched.pop_front() : mk(0, 0, 0, '0, 0);
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("busy",      bus.busy,      cur.busy);
      check("reg_load",  bus.reg_load,  cur.load);
      check("reg_clear", bus.reg_clear, cur.clear);
      check("clr_ack",   bus.clr_ack,   cur.clear);
      check("gnt",       bus.gnt,       cur.gnt);
      check("reg_d",     bus.reg_d,     m_d);
      check("last_id",   bus.last_id,   m_last);
      check("load_clear_excl", bus.reg_load & bus.reg_clear, 1'b0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.clr_req  = 1'b0;
    cyc();
    do_reset();

    // Reset values
    check("rst_last_id", bus.last_id, 3);
    check("rst_busy",    bus.busy,    0);
    check("rst_reg_d",   bus.reg_d,   0);
    check("rst_gnt",     bus.gnt,     0);

    // Single write
    bus.req = 4'b0001; bus.req_data[3:0] = 4'hA;
    cyc();
    check("sw_load", bus.reg_load, 1);
    check("sw_d",    bus.reg_d,    4'hA);
    check("sw_nognt", bus.gnt,     0);
    cyc();
    check("sw_gnt",  bus.gnt,      4'b0001);
    bus.req = '0;
    cyc();
    check("sw_idle", bus.busy,     0);
    check("sw_last", bus.last_id,  0);

    // Round-robin fairness with all four requesting continuously
    do_reset();
    bus.req_data = {4'h8, 4'h7, 4'h6, 4'h5};
    bus.req      = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      cyc();
      check("rr_load", bus.reg_load, 1);
      check("rr_d",    bus.reg_d,    (g % 4) + 5);
      cyc();
      check("rr_gnt",  bus.gnt,      32'd1 << (g % 4));
      cyc();
      check("rr_idle", bus.busy,     0);
    end
    bus.req = '0;

    // Clear beats a simultaneous write
    do_reset();
    bus.clr_req = 1'b1; bus.req = 4'b0100; bus.req_data[11:8] = 4'hC;
    cyc();
    check("cp_clear", bus.reg_clear, 1);
    check("cp_ack",   bus.clr_ack,   1);
    check("cp_noload", bus.reg_load, 0);
    bus.clr_req = 1'b0;
    cyc();
    check("cp_idle",  bus.busy,      0);
    cyc();
    check("cp_load",  bus.reg_load,  1);
    check("cp_d",     bus.reg_d,     4'hC);
    cyc();
    check("cp_gnt",   bus.gnt,       4'b0100);
    bus.req = '0;

    // Clear raised during an in-flight write waits for IDLE
    do_reset();
    bus.req = 4'b0010; bus.req_data[7:4] = 4'h3;
    cyc();
    check("cw_load",  bus.reg_load,  1);
    bus.clr_req = 1'b1;
    cyc();
    check("cw_gnt",   bus.gnt,       4'b0010);
    check("cw_noclr", bus.reg_clear, 0);
    bus.req = '0;
    cyc();
    check("cw_idle",  bus.busy,      0);
    cyc();
    check("cw_clear", bus.reg_clear, 1);
    check("cw_ack",   bus.clr_ack,   1);
    bus.clr_req = 1'b0;

    // Reset landing in LOAD abandons the write; client 3 re-wins
    do_reset();
    bus.req = 4'b1000; bus.req_data[15:12] = 4'h9;
    cyc();
    check("rl_load",  bus.reg_load,  1);
    check("rl_d",     bus.reg_d,     4'h9);
    rst = 1'b1;
    cyc();
    check("rl_gnt0",  bus.gnt,       0);
    check("rl_busy",  bus.busy,      0);
    check("rl_d0",    bus.reg_d,     0);
    check("rl_last",  bus.last_id,   3);
    rst = 1'b0;
    cyc();
    check("rl_reload", bus.reg_load, 1);
    cyc();
    check("rl_regnt", bus.gnt,       4'b1000);
    bus.req = '0;

    // Client drops req in its LOAD cycle; write still completes
    do_reset();
    bus.req = 4'b0001; bus.req_data[3:0] = 4'h5;
    cyc();
    check("ed_load",  bus.reg_load,  1);
    bus.req = '0;
    cyc();
    check("ed_gnt",   bus.gnt,       4'b0001);
    cyc();
    check("ed_last",  bus.last_id,   0);
    check("ed_idle",  bus.busy,      0);

    // Randomized clients obeying the request rules, with occasional resets
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] g_now;
      logic         ack_now;
      cyc();
      g_now   = bus.gnt;
      ack_now = bus.clr_ack;
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < N; i++) begin
        if (g_now[i]) begin
          bus.req[i] = 1'b0;
        end else if (!bus.req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.req_data[i*W +: W] = W'($urandom);
            bus.req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 39) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      if (ack_now) bus.clr_req = 1'b0;
      else if (!bus.clr_req && $urandom_range(0, 9) == 0) bus.clr_req = 1'b1;
    end
    rst = 1'b0;
    bus.req = '0;
    bus.clr_req = 1'b0;
    cyc();
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
